// File: rtl/operand_fetch.sv
// Operand fetch: 16-entry register file read side, pending-write scoreboard, RAW/WAW stall, registered operand slot.
// Optional macro FWD_BYPASS_EN: lets a source with exactly one pending write take its operand from the same-cycle writeback.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int CNT_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_we,
    input  logic [$clog2(NREG)-1:0] wb_rg,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    id_valid,
    input  logic [$clog2(NREG)-1:0] id_rs1,
    input  logic [$clog2(NREG)-1:0] id_rs2,
    input  logic [$clog2(NREG)-1:0] id_rd,
    input  logic                    id_rd_we,
    output logic                    id_stall,
    input  logic                    ex_ready,
    output logic                    ex_valid,
    output logic [DATA_W-1:0]       ex_op_a,
    output logic [DATA_W-1:0]       ex_op_b,
    output logic [$clog2(NREG)-1:0] ex_rd,
    output logic                    ex_rd_we,
    output logic                    sb_err
);

    localparam int               IDX_W   = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs        [NREG];
    logic [CNT_W-1:0]  pending     [NREG];
    logic [CNT_W-1:0]  pending_nxt [NREG];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              slot_free;
    logic              waw_limit;
    logic              accept;

    // Write-first read: a writeback to the source this cycle wins over the array.
    function automatic logic [DATA_W-1:0] read_src(input logic [IDX_W-1:0] rs);
        if (rs == '0) return '0;
        if (wb_we && wb_rg == rs) return wb_data;
        return regs[rs];
    endfunction

    function automatic logic hazard(input logic [IDX_W-1:0] rs);
        if (rs == '0) return 1'b0;
`ifdef FWD_BYPASS_EN
        if (wb_we && wb_rg == rs && pending[rs] == CNT_W'(1)) return 1'b0;
`endif
        return pending[rs] != '0;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        op_a      = read_src(id_rs1);
        op_b      = read_src(id_rs2);
        slot_free = !ex_valid || ex_ready;
        waw_limit = id_rd_we && id_rd != '0 && pending[id_rd] == CNT_MAX
                    && !(wb_we && wb_rg == id_rd);
        id_stall  = id_valid && (hazard(id_rs1) || hazard(id_rs2) || waw_limit || !slot_free);
        accept    = id_valid && !id_stall;
        for (int r = 0; r < NREG; r++) begin
            pending_nxt[r] = pending[r]
                + CNT_W'(accept && id_rd_we && id_rd != '0 && id_rd == IDX_W'(r))
                - CNT_W'(wb_we && wb_rg == IDX_W'(r) && pending[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is reset because architectural state must read 0 after reset.
            for (int r = 0; r < NREG; r++) begin
                regs[r]    <= '0;
                pending[r] <= '0;
            end
            ex_valid <= 1'b0;
            ex_op_a  <= '0;
            ex_op_b  <= '0;
            ex_rd    <= '0;
            ex_rd_we <= 1'b0;
            sb_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (wb_we && wb_rg != '0) begin
                regs[wb_rg] <= wb_data;
                if (pending[wb_rg] == '0) sb_err <= 1'b1;
            end
            for (int r = 0; r < NREG; r++) pending[r] <= pending_nxt[r];
            if (accept) begin
                ex_valid <= 1'b1;
                ex_op_a  <= op_a;
                ex_op_b  <= op_b;
                ex_rd    <= id_rd;
                ex_rd_we <= id_rd_we;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed table, hand sequences, random run against a behavioural model.
module tb_operand_fetch;

`ifdef FWD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [3:0]  wb_rg;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic        id_rd_we;
    logic        id_stall;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_op_a, ex_op_b;
    logic [3:0]  ex_rd;
    logic        ex_rd_we;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rg(wb_rg), .wb_data(wb_data),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_stall(id_stall), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .sb_err(sb_err)
    );

    typedef struct {
        logic        wb_we;
        logic [3:0]  wb_rg;
        logic [31:0] wb_data;
        logic        valid;
        logic [3:0]  rs1, rs2, rd;
        logic        rd_we;
        logic        rdy;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_a, exp_b;
        logic [3:0]  exp_rd;
        logic        exp_rd_we;
        logic        exp_err;
    } vec_t;

    // Behavioural model state
    logic [31:0] m_regs [16];
    int          m_pend [16];
    logic        m_valid, m_rd_we, m_err;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int we, input int rg, input logic [31:0] data, input int valid,
                         input int rs1, input int rs2, input int rd, input int rd_we, input int rdy);
        wb_we    = 1'(we);
        wb_rg    = 4'(rg);
        wb_data  = data;
        id_valid = 1'(valid);
        id_rs1   = 4'(rs1);
        id_rs2   = 4'(rs2);
        id_rd    = 4'(rd);
        id_rd_we = 1'(rd_we);
        ex_ready = 1'(rdy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        {m_valid, m_rd_we, m_err, m_a, m_b, m_rd} = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] rs);
        if (rs == 0) return 0;
        if (wb_we && wb_rg == rs) return wb_data;
        return m_regs[rs];
    endfunction

    function automatic logic m_hazard(input logic [3:0] rs);
        if (rs == 0 || m_pend[rs] == 0) return 1'b0;
        return !(BYP && wb_we && wb_rg == rs && m_pend[rs] == 1);
    endfunction

    initial begin
        vec_t tbl [10];
        logic exp_stall, acc;
        logic [31:0] na, nb;
        int q [$];

        do_reset();
        check("reset_ex_valid", ex_valid, 0);
        check("reset_op_a", ex_op_a, 0);
        check("reset_op_b", ex_op_b, 0);
        check("reset_ex_rd", ex_rd, 0);
        check("reset_ex_rd_we", ex_rd_we, 0);
        check("reset_sb_err", sb_err, 0);
        check("reset_stall", id_stall, 0);

        // wb_we rg data valid rs1 rs2 rd rd_we rdy | stall valid a b rd rd_we err
        tbl = '{
            '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1},
            '{0, 0, 0,            1, 3, 0, 0, 0, 1,  0, 1, 32'hDEADBEEF, 0, 0, 0, 1},
            '{0, 0, 0,            1, 0, 0, 7, 1, 1,  0, 1, 0, 0, 7, 1, 1},
            '{0, 0, 0,            1, 0, 0, 7, 1, 1,  0, 1, 0, 0, 7, 1, 1},
            '{0, 0, 0,            1, 0, 0, 7, 1, 1,  0, 1, 0, 0, 7, 1, 1},
            '{0, 0, 0,            1, 0, 0, 7, 1, 1,  1, 0, 0, 0, 0, 0, 1},
            '{1, 7, 32'h77,       1, 0, 0, 7, 1, 1,  0, 1, 0, 0, 7, 1, 1},
            '{0, 0, 0,            1, 7, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1},
            '{1, 9, 32'h99,       0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1},
            '{0, 0, 0,            1, 9, 3, 0, 0, 1,  0, 1, 32'h99, 32'hDEADBEEF, 0, 0, 1}
        };
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wb_we, tbl[i].wb_rg, tbl[i].wb_data, tbl[i].valid, tbl[i].rs1,
                  tbl[i].rs2, tbl[i].rd, tbl[i].rd_we, tbl[i].rdy);
            #1;
            check($sformatf("tbl%0d_stall", i), id_stall, tbl[i].exp_stall);
            tick();
            check($sformatf("tbl%0d_valid", i), ex_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d_err", i), sb_err, tbl[i].exp_err);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_op_a", i), ex_op_a, tbl[i].exp_a);
                check($sformatf("tbl%0d_op_b", i), ex_op_b, tbl[i].exp_b);
                check($sformatf("tbl%0d_rd", i), ex_rd, tbl[i].exp_rd);
                check($sformatf("tbl%0d_rd_we", i), ex_rd_we, tbl[i].exp_rd_we);
            end
        end

        // RAW on R5 resolved by writeback, with or without same-cycle bypass
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 5, 1, 1); #1;
        check("raw_issue_rd5", id_stall, 0);
        tick();
        check("raw_ex_rd", ex_rd, 5);
        drive(0, 0, 0, 1, 5, 0, 0, 0, 1); #1;
        check("raw_stall_pending", id_stall, 1);
        tick();
        check("raw_bubble", ex_valid, 0);
        drive(1, 5, 32'h12, 1, 5, 0, 0, 0, 1); #1;
        check("raw_stall_on_wb", id_stall, !BYP);
        tick();
        check("raw_valid_after_wb", ex_valid, BYP);
        drive(0, 0, 0, 1, 5, 0, 0, 0, 1); #1;
        check("raw_stall_after_wb", id_stall, 0);
        tick();
        check("raw_op_a", ex_op_a, 32'h12);
        check("raw_no_err", sb_err, 0);

        // Back-pressure hold for 3 cycles, then the new bundle loads
        drive(0, 0, 0, 1, 0, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_stall", id_stall, 1);
            tick();
            check("hold_valid", ex_valid, 1);
            check("hold_op_a", ex_op_a, 32'h12);
            check("hold_op_b", ex_op_b, 0);
        end
        ex_ready = 1'b1; #1;
        check("release_stall", id_stall, 0);
        tick();
        check("release_op_a", ex_op_a, 0);
        check("release_op_b", ex_op_b, 32'h12);

        // Reset mid-operation drops the pending write to R4 and the held bundle
        drive(0, 0, 0, 1, 0, 0, 4, 1, 1);
        tick();
        check("mid_pre_valid", ex_valid, 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_valid", ex_valid, 0);
        check("mid_rst_rd", ex_rd, 0);
        drive(0, 0, 0, 1, 4, 0, 0, 0, 1); #1;
        check("mid_rs4_not_stalled", id_stall, 0);
        tick();

        // Writeback to a non-pending register: sticky error, data still written
        drive(1, 9, 32'h55, 0, 0, 0, 0, 0, 1);
        tick();
        check("err_set", sb_err, 1);
        drive(0, 0, 0, 1, 9, 0, 0, 0, 1);
        tick();
        check("err_r9_data", ex_op_a, 32'h55);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        check("err_sticky", sb_err, 1);

        // Random traffic against the model; writebacks only target pending registers
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            q.delete();
            for (int r = 1; r < 16; r++) if (m_pend[r] != 0) q.push_back(r);
            if (q.size() != 0 && $urandom_range(1, 0) == 1)
                drive(1, q[$urandom_range(q.size() - 1, 0)], $urandom, 0, 0, 0, 0, 0, 0);
            else
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            id_valid = $urandom_range(3, 0) != 0;
            id_rs1   = 4'($urandom_range(7, 0));
            id_rs2   = 4'($urandom_range(7, 0));
            id_rd    = 4'($urandom_range(7, 0));
            id_rd_we = 1'($urandom_range(1, 0));
            ex_ready = $urandom_range(3, 0) != 0;
            #1;
            exp_stall = id_valid && (m_hazard(id_rs1) || m_hazard(id_rs2) || !(!m_valid || ex_ready)
                        || (id_rd_we && id_rd != 0 && m_pend[id_rd] == 3 && !(wb_we && wb_rg == id_rd)));
            check("rnd_stall", id_stall, exp_stall);
            acc = id_valid && !exp_stall;
            na  = m_read(id_rs1);
            nb  = m_read(id_rs2);
            if (acc) begin
                m_valid = 1'b1;
                m_a     = na;
                m_b     = nb;
                m_rd    = id_rd;
                m_rd_we = id_rd_we;
            end else if (ex_ready) begin
                m_valid = 1'b0;
            end
            if (wb_we && wb_rg != 0) begin
                m_regs[wb_rg] = wb_data;
                if (m_pend[wb_rg] == 0) m_err = 1'b1;
                else m_pend[wb_rg]--;
            end
            if (acc && id_rd_we && id_rd != 0) m_pend[id_rd]++;
            tick();
            check("rnd_valid", ex_valid, m_valid);
            check("rnd_op_a", ex_op_a, m_a);
            check("rnd_op_b", ex_op_b, m_b);
            check("rnd_rd", ex_rd, m_rd);
            check("rnd_rd_we", ex_rd_we, m_rd_we);
            check("rnd_err", sb_err, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
